// File: rtl/syndrome_collector_pkg.sv
// Shared frame-size constants and the syndrome entry layout used by the
// decoder stages that exchange per-codeword check summaries.
//   I        : check rows per codeword
//   WWIDTH   : width of the unsatisfied-check weight (holds 0..I)
//   CWIDTH   : width of the row counter (holds 0..I-1)
//   syn_entry_t : {syn[I-1:0], weight[WWIDTH-1:0], ok}
package syndrome_collector_pkg;

  localparam int I       = 7;
  localparam int WWIDTH  = $clog2(I + 1);
  localparam int CWIDTH  = (I > 1) ? $clog2(I) : 1;
  localparam int ENTRY_W = I + WWIDTH + 1;

  typedef struct packed {
    logic [I-1:0]      syn;
    logic [WWIDTH-1:0] weight;
    logic              ok;
  } syn_entry_t;

  // Build a completed entry; ok is derived from the weight so the two can
  // never disagree downstream.
  function automatic syn_entry_t make_entry(input logic [I-1:0]      syn,
                                            input logic [WWIDTH-1:0] weight);
    syn_entry_t e;
    e.syn    = syn;
    e.weight = weight;
    e.ok     = (weight == {WWIDTH{1'b0}});
    return e;
  endfunction

endpackage

// File: rtl/syndrome_collector_fifo.sv
// syn_out_fifo: 2-entry synchronous FIFO with valid/ready handshake.
// The head entry lives in its own register and drives the outputs directly,
// so the outputs are registered, stay stable under backpressure, and keep the
// last popped value when the FIFO runs empty.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   push_i        : write request for din_i
//   push_ready_o  : write will be accepted this cycle (not full, or popping)
//   din_i         : entry to write
//   full_o        : both entries occupied
//   dout_o        : head entry
//   out_valid_o   : head entry valid
//   out_ready_i   : consumer accepts head when out_valid_o is high
module syn_out_fifo
  import syndrome_collector_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  output logic       push_ready_o,
  input  syn_entry_t din_i,
  output logic       full_o,
  output syn_entry_t dout_o,
  output logic       out_valid_o,
  input  logic       out_ready_i
);

  syn_entry_t head_q, head_d;
  syn_entry_t tail_q, tail_d;
  logic       head_vld_q, head_vld_d;
  logic       tail_vld_q, tail_vld_d;
  logic       pop_s;
  logic       push_s;

  assign pop_s        = head_vld_q & out_ready_i;
  assign full_o       = head_vld_q & tail_vld_q;
  // A pop frees a slot on the same edge, so a full FIFO can still accept.
  assign push_ready_o = ~full_o | pop_s;
  assign push_s       = push_i & push_ready_o;

  // Next-state for the two slots: head always holds the oldest entry.
  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    head_vld_d = head_vld_q;
    tail_vld_d = tail_vld_q;
    case ({pop_s, push_s})
      2'b01: begin
        if (!head_vld_q) begin
          head_d     = din_i;
          head_vld_d = 1'b1;
        end else begin
          tail_d     = din_i;
          tail_vld_d = 1'b1;
        end
      end
      2'b10: begin
        if (tail_vld_q) begin
          head_d     = tail_q;
          tail_vld_d = 1'b0;
        end else begin
          // Data left in place: outputs keep the last popped entry.
          head_vld_d = 1'b0;
        end
      end
      2'b11: begin
        if (tail_vld_q) begin
          head_d = tail_q;
          tail_d = din_i;
        end else begin
          head_d = din_i;
        end
      end
      default: begin
        head_d = head_q;
      end
    endcase
  end

  // Slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      head_vld_q <= 1'b0;
      tail_vld_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      head_vld_q <= head_vld_d;
      tail_vld_q <= tail_vld_d;
    end
  end

  assign dout_o      = head_q;
  assign out_valid_o = head_vld_q;

endmodule

// File: rtl/syndrome_collector.sv
// syndrome_collector: gathers the I serial row-check results of a codeword
// into a syndrome and unsatisfied-check weight, and hands each completed
// codeword summary to the decoder control through a 2-entry output FIFO.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   F_value         : row check result, 1 = satisfied
//   F_value_tvalid  : qualifies F_value, one row per pulse
//   frame_sync      : abandon the partial frame, restart at row 0
//   syn             : syndrome, bit k set when row k unsatisfied
//   syn_weight      : number of unsatisfied rows
//   cw_ok           : syndrome is all zero
//   syn_tvalid      : output entry valid
//   syn_tready      : consumer ready
//   overflow        : sticky, a completed frame was dropped (FIFO full)
module syndrome_collector
  import syndrome_collector_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              F_value,
  input  logic              F_value_tvalid,
  input  logic              frame_sync,
  output logic [I-1:0]      syn,
  output logic [WWIDTH-1:0] syn_weight,
  output logic              cw_ok,
  output logic              syn_tvalid,
  input  logic              syn_tready,
  output logic              overflow
);

  localparam logic [CWIDTH-1:0] LAST_ROW = CWIDTH'(I - 1);

  logic [CWIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [I-1:0]      part_syn_q, part_syn_d;
  logic [WWIDTH-1:0] part_w_q, part_w_d;
  logic              overflow_q, overflow_d;

  logic              bad_s;
  logic [I-1:0]      bad_bit0_s;
  logic [WWIDTH-1:0] bad_w_s;
  logic [I-1:0]      full_syn_s;
  logic [WWIDTH-1:0] full_w_s;
  logic              frame_end_s;
  logic              fifo_ready_s;
  logic              fifo_full_s;
  syn_entry_t        push_entry_s;
  syn_entry_t        head_s;

  assign bad_s      = ~F_value;
  assign bad_bit0_s = {{(I-1){1'b0}}, bad_s};
  assign bad_w_s    = {{(WWIDTH-1){1'b0}}, bad_s};

  // The final row is folded in combinationally so the entry is pushed on the
  // same edge as the last valid.
  assign full_syn_s   = part_syn_q | (bad_bit0_s << row_cnt_q);
  assign full_w_s     = part_w_q + bad_w_s;
  assign frame_end_s  = F_value_tvalid & (row_cnt_q == LAST_ROW) & ~frame_sync;
  assign push_entry_s = make_entry(full_syn_s, full_w_s);

  // Row counter and partial syndrome/weight next state.
  always_comb begin
    row_cnt_d  = row_cnt_q;
    part_syn_d = part_syn_q;
    part_w_d   = part_w_q;
    if (frame_sync) begin
      // A coincident valid becomes row 0 of the new frame.
      if (F_value_tvalid) begin
        row_cnt_d  = CWIDTH'(1);
        part_syn_d = bad_bit0_s;
        part_w_d   = bad_w_s;
      end else begin
        row_cnt_d  = {CWIDTH{1'b0}};
        part_syn_d = {I{1'b0}};
        part_w_d   = {WWIDTH{1'b0}};
      end
    end else if (F_value_tvalid) begin
      if (row_cnt_q == LAST_ROW) begin
        row_cnt_d  = {CWIDTH{1'b0}};
        part_syn_d = {I{1'b0}};
        part_w_d   = {WWIDTH{1'b0}};
      end else begin
        row_cnt_d  = row_cnt_q + CWIDTH'(1);
        part_syn_d = full_syn_s;
        part_w_d   = full_w_s;
      end
    end else begin
      row_cnt_d = row_cnt_q;
    end
  end

  // Sticky overflow: a completed frame that the FIFO cannot take is lost.
  always_comb begin
    overflow_d = overflow_q;
    if (frame_end_s && !fifo_ready_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Accumulator and overflow registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_q  <= {CWIDTH{1'b0}};
      part_syn_q <= {I{1'b0}};
      part_w_q   <= {WWIDTH{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      row_cnt_q  <= row_cnt_d;
      part_syn_q <= part_syn_d;
      part_w_q   <= part_w_d;
      overflow_q <= overflow_d;
    end
  end

  syn_out_fifo u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (frame_end_s),
    .push_ready_o (fifo_ready_s),
    .din_i        (push_entry_s),
    .full_o       (fifo_full_s),
    .dout_o       (head_s),
    .out_valid_o  (syn_tvalid),
    .out_ready_i  (syn_tready)
  );

  assign syn        = head_s.syn;
  assign syn_weight = head_s.weight;
  assign cw_ok      = head_s.ok;
  assign overflow   = overflow_q;

  // Full state is implied by push_ready; kept visible for debug probing.
  logic unused_full_s;
  assign unused_full_s = fifo_full_s;

endmodule

// File: tb/tb_syndrome_collector.sv
// Scoreboard bench for syndrome_collector: the driver feeds rows and a
// frame-level reference model; completed frames are queued as expected
// entries and a negedge monitor compares the DUT output against them.
module tb_syndrome_collector;
  import syndrome_collector_pkg::*;

  typedef logic [I+WWIDTH:0] ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              F_value = 1'b0;
  logic              F_value_tvalid = 1'b0;
  logic              frame_sync = 1'b0;
  logic [I-1:0]      syn;
  logic [WWIDTH-1:0] syn_weight;
  logic              cw_ok;
  logic              syn_tvalid;
  logic              syn_tready = 1'b0;
  logic              overflow;

  syndrome_collector dut (
    .clk            (clk),
    .rst            (rst),
    .F_value        (F_value),
    .F_value_tvalid (F_value_tvalid),
    .frame_sync     (frame_sync),
    .syn            (syn),
    .syn_weight     (syn_weight),
    .cw_ok          (cw_ok),
    .syn_tvalid     (syn_tvalid),
    .syn_tready     (syn_tready),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  // Model state
  ent_t exp_q[$];
  ent_t last_pop = '0;
  bit   exp_ovf = 1'b0;
  bit   pend_valid = 1'b0;
  ent_t pend_ent = '0;
  bit   pend_ovf = 1'b0;
  bit   rows[$];
  bit   rand_ready = 1'b0;
  bit   ready_fix = 1'b1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Frame-level reference: syndrome bit k set for each failing row k.
  function automatic ent_t ref_frame();
    logic [I-1:0] s;
    int w;
    s = '0;
    w = 0;
    for (int k = 0; k < I; k++) begin
      if (!rows[k]) begin
        s[k] = 1'b1;
        w++;
      end
    end
    return {s, WWIDTH'(w), (w == 0)};
  endfunction

  task automatic commit();
    if (pend_valid) exp_q.push_back(pend_ent);
    if (pend_ovf) exp_ovf = 1'b1;
    pend_valid = 1'b0;
    pend_ovf = 1'b0;
  endtask

  task automatic model_step(input bit v, input bit f, input bit fs, input bit rdy);
    ent_t e;
    bit pop_now;
    if (fs) begin
      rows.delete();
      if (v) rows.push_back(f);
    end else if (v) begin
      rows.push_back(f);
      if (rows.size() == I) begin
        e = ref_frame();
        rows.delete();
        pop_now = (exp_q.size() > 0) && rdy;
        if (exp_q.size() >= 2 && !pop_now) begin
          pend_ovf = 1'b1;
        end else begin
          pend_valid = 1'b1;
          pend_ent = e;
        end
      end
    end
  endtask

  task automatic cycle(input bit v, input bit f, input bit fs);
    bit rdy;
    @(posedge clk);
    #1;
    commit();
    rdy = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fix;
    F_value_tvalid = v;
    F_value = f;
    frame_sync = fs;
    syn_tready = rdy;
    model_step(v, f, fs, rdy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_rows(input logic [I-1:0] fv, input int first, input int cnt, input int gap_max);
    for (int k = first; k < first + cnt; k++) begin
      int g;
      g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      for (int j = 0; j < g; j++) cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b1, fv[k], 1'b0);
    end
  endtask

  task automatic send_frame(input logic [I-1:0] fv, input int gap_max);
    send_rows(fv, 0, I, gap_max);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    F_value_tvalid = 1'b0;
    frame_sync = 1'b0;
    exp_q.delete();
    rows.delete();
    pend_valid = 1'b0;
    pend_ovf = 1'b0;
    exp_ovf = 1'b0;
    last_pop = '0;
    #1;
    chk("reset outputs", 32'({syn, syn_weight, cw_ok, syn_tvalid, overflow}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: compare head entry, idle hold value and overflow each cycle.
  always @(negedge clk) begin
    chk("syn_tvalid", 32'(syn_tvalid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("head entry", 32'({syn, syn_weight, cw_ok}), 32'(exp_q[0]));
      if (syn_tready) begin
        last_pop = exp_q[0];
        void'(exp_q.pop_front());
      end
    end else begin
      chk("idle hold", 32'({syn, syn_weight, cw_ok}), 32'(last_pop));
    end
    chk("overflow", 32'(overflow), 32'(exp_ovf));
  end

  initial begin
    do_reset();

    // All satisfied, then the reference pattern 0,1,1,0,1,1,0 (row0 first)
    ready_fix = 1'b1;
    send_frame(7'h7F, 0);
    idle(2);
    send_frame(7'b0110110, 0);
    idle(3);

    // Backpressure: two frames held, third dropped, then drained in order
    ready_fix = 1'b0;
    for (int f = 0; f < 3; f++) send_frame(7'($urandom), 0);
    idle(3);
    ready_fix = 1'b1;
    idle(5);

    // frame_sync standalone after 4 rows, then 7 failing rows
    send_rows(7'h55, 0, 4, 0);
    cycle(1'b0, 1'b0, 1'b1);
    send_frame(7'h00, 0);
    idle(2);
    // frame_sync coincident with a row valid
    send_rows(7'h2A, 0, 4, 0);
    cycle(1'b1, 1'b0, 1'b1);
    send_rows(7'h00, 1, 6, 0);
    idle(2);
    // frame_sync coincident with the frame-end valid
    send_rows(7'h13, 0, 6, 0);
    cycle(1'b1, 1'b1, 1'b1);
    send_rows(7'h4C, 1, 6, 0);
    idle(3);

    // Reset with a partial frame and a non-empty FIFO
    ready_fix = 1'b0;
    send_frame(7'h0F, 0);
    send_rows(7'h00, 0, 3, 0);
    do_reset();
    ready_fix = 1'b1;
    send_frame(7'h3C, 0);
    idle(3);

    // Full FIFO with simultaneous pop and push at frame end
    ready_fix = 1'b0;
    send_frame(7'h01, 0);
    send_frame(7'h02, 0);
    send_rows(7'h04, 0, I - 1, 0);
    ready_fix = 1'b1;
    send_rows(7'h04, I - 1, 1, 0);
    idle(4);

    // Random gaps and random consumer readiness
    rand_ready = 1'b1;
    for (int f = 0; f < 20; f++) send_frame(7'($urandom), 3);
    rand_ready = 1'b0;
    ready_fix = 1'b1;

    for (int n = 0; n < 40 && (exp_q.size() > 0 || pend_valid); n++) idle(1);
    idle(2);
    chk("drain empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
